// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I opcode constants, immediate formats and decoded-entry type
package decode_pkg;

    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_IMM      = 7'h13;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_OP       = 7'h33;
    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_JAL      = 7'h6F;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_generator.sv
// rtl/imm_generator.sv - combinational RV32I immediate format select and assembly
module imm_generator
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output imm_fmt_e    fmt
);

    always_comb begin
        fmt = FMT_NONE;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                            fmt = FMT_S;
            OP_BRANCH:                           fmt = FMT_B;
            OP_LUI, OP_AUIPC:                    fmt = FMT_U;
            OP_JAL:                              fmt = FMT_J;
            default:                             fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - FIFO of RV32I instructions decoded at push, head held in a register
module inst_decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        decoded_t        dec;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_q;
    entry_t          head_next;
    entry_t          new_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_next;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            do_push;
    logic            do_pop;
    logic [31:0]     gen_imm;
    imm_fmt_e        gen_fmt;

    imm_generator u_imm_generator (
        .inst (in_inst),
        .imm  (gen_imm),
        .fmt  (gen_fmt)
    );

    assign in_ready  = !reset && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign do_push   = in_valid && in_ready && !flush;
    assign do_pop    = out_valid && out_ready && !flush;

    always_comb begin
        new_entry             = '0;
        new_entry.dec.opcode  = in_inst[6:0];
        new_entry.dec.funct3  = in_inst[14:12];
        new_entry.dec.funct7  = in_inst[31:25];
        new_entry.dec.rd      = in_inst[11:7];
        new_entry.dec.rs1     = in_inst[19:15];
        new_entry.dec.rs2     = in_inst[24:20];
        new_entry.dec.imm     = (gen_fmt == FMT_NONE) ? '0 : gen_imm;
        new_entry.dec.illegal = !is_legal_opcode(in_inst[6:0]);
        new_entry.pc          = in_pc;
    end

    // The head register is loaded with whatever will sit at the read pointer after this
    // edge; a push landing on that slot is forwarded since the array write is not yet visible.
    always_comb begin
        rd_next    = rd_ptr + PW'(do_pop);
        count_next = count_q + CW'(do_push) - CW'(do_pop);
        head_next  = head_q;
        if (count_next != '0) begin
            head_next = (do_push && (wr_ptr == rd_next)) ? new_entry : mem[rd_next];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(do_push);
            rd_ptr  <= rd_next;
            count_q <= count_next;
            head_q  <= head_next;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    assign out_opcode  = head_q.dec.opcode;
    assign out_funct3  = head_q.dec.funct3;
    assign out_funct7  = head_q.dec.funct7;
    assign out_rd      = head_q.dec.rd;
    assign out_rs1     = head_q.dec.rs1;
    assign out_rs2     = head_q.dec.rs2;
    assign out_imm     = head_q.dec.imm;
    assign out_illegal = head_q.dec.illegal;
    assign out_pc      = head_q.pc;
    assign count       = count_q;

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb/tb_inst_decode_queue.sv - scoreboard bench for inst_decode_queue with a behavioural decode model
module tb_inst_decode_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic [CW-1:0]   count;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t last_payload = '0;
    exp_t act;
    int   checks = 0;
    int   errors = 0;
    int   start_size = 0;

    logic [6:0] legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                   7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    assign act = {out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                  out_imm, out_illegal, out_pc};

    inst_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_illegal (out_illegal),
        .count       (count)
    );

    always #5 clock = ~clock;

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   v;
        bit   legal;
        legal = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == inst[6:0]) legal = 1'b1;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = int'($signed(inst[31:20]));
            7'h23: v = int'($signed({inst[31:25], inst[11:7]}));
            7'h63: v = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) * 2;
            7'h37, 7'h17: v = int'(inst & 32'hFFFF_F000);
            7'h6F: v = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) * 2;
            default: v = 0;
        endcase
        e.opcode  = inst[6:0];
        e.funct3  = inst[14:12];
        e.funct7  = inst[31:25];
        e.rd      = inst[11:7];
        e.rs1     = inst[19:15];
        e.rs2     = inst[24:20];
        e.imm     = v;
        e.illegal = !legal;
        e.pc      = pc;
        return e;
    endfunction

    task automatic check(input string name, input logic [96:0] got, input logic [96:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compares the DUT against the scoreboard mid-cycle, then retires entries.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            start_size = sb.size();
            check("count", 97'(count), 97'(start_size));
            check("out_valid", 97'(out_valid), 97'(start_size != 0));
            check("in_ready", 97'(in_ready), 97'(!reset && start_size < DEPTH));
            if (start_size != 0) begin
                check("head", act, sb[0]);
                last_payload = sb[0];
            end else begin
                check("idle_payload", act, last_payload);
            end
            if (reset) begin
                sb.delete();
                last_payload = '0;
            end else if (flush) begin
                sb.delete();
            end else if (start_size != 0 && out_ready) begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        @(posedge clock);
        #1;
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        #2;
        if (iv && !r && !f && start_size < DEPTH) sb.push_back(ref_decode(inst, pc));
    endtask

    initial begin
        logic [31:0] w;
        int          sel;

        cycle(1, 0, 0, 0, 0, 0);
        check("reset_in_ready", 97'(in_ready), 97'(0));
        cycle(1, 0, 0, 0, 0, 0);

        // addi x1,x2,5
        cycle(0, 0, 1, 32'h0051_0093, 32'h100, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("addi_valid", 97'(out_valid), 97'(1));
        check("addi_opcode", 97'(out_opcode), 97'(7'h13));
        check("addi_rd", 97'(out_rd), 97'(1));
        check("addi_rs1", 97'(out_rs1), 97'(2));
        check("addi_funct3", 97'(out_funct3), 97'(0));
        check("addi_imm", 97'(out_imm), 97'(5));
        check("addi_pc", 97'(out_pc), 97'(32'h100));
        check("addi_illegal", 97'(out_illegal), 97'(0));

        // sw x1,-4(x2)
        cycle(0, 0, 1, 32'hFE11_2E23, 32'h104, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("sw_opcode", 97'(out_opcode), 97'(7'h23));
        check("sw_rs1", 97'(out_rs1), 97'(2));
        check("sw_rs2", 97'(out_rs2), 97'(1));
        check("sw_funct3", 97'(out_funct3), 97'(2));
        check("sw_imm", 97'(out_imm), 97'(32'hFFFF_FFFC));

        cycle(0, 0, 1, 32'h0000_0000, 32'h108, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("zero_valid", 97'(out_valid), 97'(1));
        check("zero_illegal", 97'(out_illegal), 97'(1));
        check("zero_imm", 97'(out_imm), 97'(0));
        cycle(0, 0, 0, 0, 0, 1);

        // Fill with consumer stalled, then drain; third entry waits for space.
        cycle(0, 0, 1, 32'h0010_0113, 32'h200, 0);
        cycle(0, 0, 1, 32'h0020_0193, 32'h204, 0);
        cycle(0, 0, 1, 32'h0030_0213, 32'h208, 0);
        check("full_in_ready", 97'(in_ready), 97'(0));
        check("full_count", 97'(count), 97'(2));
        cycle(0, 0, 1, 32'h0030_0213, 32'h208, 1);
        cycle(0, 0, 1, 32'h0030_0213, 32'h208, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Flush while full with a simultaneous push.
        cycle(0, 0, 1, 32'h0040_0293, 32'h300, 0);
        cycle(0, 0, 1, 32'h0050_0313, 32'h304, 0);
        cycle(0, 1, 1, 32'h0060_0393, 32'h308, 0);
        cycle(0, 0, 0, 0, 0, 1);
        check("flush_count", 97'(count), 97'(0));
        check("flush_valid", 97'(out_valid), 97'(0));
        cycle(0, 0, 0, 0, 0, 1);

        // Reset with one entry held.
        cycle(0, 0, 1, 32'h0070_0413, 32'h400, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("rst_count", 97'(count), 97'(0));
        check("rst_valid", 97'(out_valid), 97'(0));
        check("rst_payload", act, 97'(0));

        for (int i = 0; i < 3000; i++) begin
            w   = $urandom;
            sel = $urandom_range(0, 13);
            if (sel < 11) w[6:0] = legal_ops[sel];
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0, w, $urandom, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_decode_queue.md
INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

Interface
REQ-001 Parameter DEPTH, default 2, entries held; power of two, >= 2.
REQ-002 Parameter XLEN, default 32, PC width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 flush  in  1  discard all held and incoming entries.
REQ-007 in_valid  in  1  in_inst/in_pc valid.
REQ-008 in_ready  out  1  queue can accept.
REQ-009 in_inst  in  32  raw RV32I instruction.
REQ-010 in_pc  in  XLEN  instruction address.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  consumer takes head.
REQ-013 out_opcode/out_funct3/out_funct7/out_rd/out_rs1/out_rs2  out  7/3/7/5/5/5  fields of inst bits [6:0]/[14:12]/[31:25]/[11:7]/[19:15]/[24:20].
REQ-014 out_imm  out  32  sign-extended immediate.
REQ-015 out_pc  out  XLEN  PC of head entry.
REQ-016 out_illegal  out  1  head instruction not a legal RV32I opcode.
REQ-017 count  out  $clog2(DEPTH+1)  entries held.

Function
REQ-018 Push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 Decode (fields, immediate, illegal) SHALL be done at push and stored; outputs come from registered head, no combinational in_*->out_* path.
REQ-020 Latency: entry pushed in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 at the earliest.
REQ-021 in_ready = (count < DEPTH); no push when full, even with simultaneous pop.
REQ-022 out_valid = (count != 0); out_* payload holds last value when empty.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
REQ-024 Pointers SHALL wrap modulo DEPTH; strict FIFO order.
REQ-025 Immediate by opcode: I (0x03,0x13,0x67,0x73) inst[31:20]; S (0x23) {inst[31:25],inst[11:7]}; B (0x63) {inst[31],inst[7],inst[30:25],inst[11:8],0}; U (0x37,0x17) {inst[31:12],12'b0}; J (0x6F) {inst[31],inst[19:12],inst[20],inst[30:21],0}; sign-extended from bit 31; other opcodes 0.
REQ-026 out_illegal = 1 when opcode not in {0x03,0x0F,0x13,0x17,0x23,0x33,0x37,0x63,0x67,0x6F,0x73}; illegal entries still queued.
REQ-027 flush: count=0, pointers=0 next cycle; same-cycle push and pop ignored; flush has priority over push/pop.
REQ-028 out_valid SHALL stay stable and payload unchanged while out_valid && !out_ready.

Reset
REQ-029 On reset: count=0, pointers=0, out_valid=0, in_ready=0 during reset cycle then 1, all out_* payload=0.
REQ-030 Reset mid-operation discards all entries; reset has priority over flush, push, pop.

Structure
REQ-031 Package decode_pkg SHALL hold opcode constants, imm-format enum (FMT_I,S,B,U,J,NONE), and decoded-entry struct.
REQ-032 Sub-module imm_generator: combinational inst -> imm and format; storage SHALL be a flat register array of decoded-entry structs.

Verification
REQ-033 Push 0x00510093 (addi x1,x2,5), pc 0x100, out_ready=1 -> next cycle out_valid=1, opcode 0x13, rd 1, rs1 2, funct3 0, imm 5, pc 0x100, illegal 0.
REQ-034 Push 0xFE112E23 (sw x1,-4(x2)) -> opcode 0x23, rs1 2, rs2 1, funct3 2, imm 0xFFFFFFFC.
REQ-035 Push 0x00000000 -> out_illegal=1, imm 0, entry still delivered.
REQ-036 DEPTH=2, out_ready=0, three pushes -> first two accepted, in_ready=0, count=2; raise out_ready -> pops in order, third then accepted.
REQ-037 count=2 with flush=1 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, pushed entry lost.
REQ-038 reset=1 with count=1 -> next cycle count=0, out_valid=0, payload 0.
